// File: rtl/axi_lite_clint_slave.sv
// axi_lite_clint_slave
//   AXI-lite responder for a CLINT-style machine timer. It holds the 64-bit
//   mtime counter and the mtimecmp compare register, and can optionally hold
//   an msip software-interrupt bit. It drives the registered timer interrupt
//   (mtip) and the software interrupt (msip) toward the core.
//
//   Register map (decoded on addr[15:3]):
//     0x0000 msip      bit0 only (present only when CLINT_MSIP_EN is defined)
//     0x4000 mtimecmp  64-bit
//     0xBFF8 mtime     64-bit
//   Any other offset answers SLVERR: writes are dropped and reads return 0.
//
//   Build option: define CLINT_MSIP_EN to include the msip register. When it
//   is not defined, offset 0x0000 is unmapped and msip is tied to 0.
//
// Ports:
//   clk, rst               sole clock; synchronous active-high reset
//   s_aw*, s_w*, s_b*      AXI-lite write address / data / response channels
//   s_ar*, s_r*            AXI-lite read address / data channels
//   mtip                   timer interrupt pending (registered)
//   msip                   software interrupt pending
module axi_lite_clint_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic                    mtip,
  output logic                    msip
);

  localparam logic [12:0] OFF_MTIMECMP = 13'h0800;
  localparam logic [12:0] OFF_MTIME    = 13'h17FF;
`ifdef CLINT_MSIP_EN
  localparam logic [12:0] OFF_MSIP     = 13'h0000;
`endif
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state, w_state_next;
  r_state_t    r_state, r_state_next;

  logic        aw_captured, w_captured;
  logic [12:0] aw_addr_q;
  logic [63:0] w_data_q;
  logic [7:0]  w_strb_q;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic [12:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        sel_mtime, sel_mtimecmp, wr_mapped;
  logic [63:0] rd_value;
  logic        rd_mapped;
  logic [63:0] mtime, mtimecmp;
  logic [15:0] tick_cnt;
  logic        tick;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{s_awaddr[ADDR_WIDTH-1:16], s_awaddr[2:0],
                              s_araddr[ADDR_WIDTH-1:16], s_araddr[2:0]};

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Handshakes are derived from registered state only, so the ready outputs
  // never loop back through the commit decision.
  assign aw_hs = (w_state == W_IDLE) && !aw_captured && s_awvalid;
  assign w_hs  = (w_state == W_IDLE) && !w_captured && s_wvalid;
  assign ar_hs = (r_state == R_IDLE) && s_arvalid;

  // The channel arriving this cycle is used directly, so the commit happens on
  // the edge of the later handshake rather than one cycle after it.
  assign wr_addr = aw_captured ? aw_addr_q : s_awaddr[15:3];
  assign wr_data = w_captured  ? w_data_q  : s_wdata;
  assign wr_strb = w_captured  ? w_strb_q  : s_wstrb;
  assign commit  = (w_state == W_IDLE) && (aw_captured || aw_hs) && (w_captured || w_hs);

  assign sel_mtime    = (wr_addr == OFF_MTIME);
  assign sel_mtimecmp = (wr_addr == OFF_MTIMECMP);
`ifdef CLINT_MSIP_EN
  assign wr_mapped = sel_mtime || sel_mtimecmp || (wr_addr == OFF_MSIP);
`else
  assign wr_mapped = sel_mtime || sel_mtimecmp;
`endif

  // Write FSM state register plus the latched AW/W beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      s_bresp     <= RESP_OKAY;
    end else begin
      w_state <= w_state_next;
      if (aw_hs) begin
        aw_captured <= 1'b1;
        aw_addr_q   <= s_awaddr[15:3];
      end
      if (w_hs) begin
        w_captured <= 1'b1;
        w_data_q   <= s_wdata;
        w_strb_q   <= s_wstrb;
      end
      if (commit) s_bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      if (w_state == W_RESP && s_bready) begin
        aw_captured <= 1'b0;
        w_captured  <= 1'b0;
      end
    end
  end

  // Write FSM next state and channel outputs.
  always_comb begin
    w_state_next = w_state;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_awready = !aw_captured;
        s_wready  = !w_captured;
        if (commit) w_state_next = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Read data mux from the current register contents.
  always_comb begin
    rd_value  = '0;
    rd_mapped = 1'b0;
    case (s_araddr[15:3])
      OFF_MTIMECMP: begin rd_value = mtimecmp; rd_mapped = 1'b1; end
      OFF_MTIME:    begin rd_value = mtime;    rd_mapped = 1'b1; end
`ifdef CLINT_MSIP_EN
      OFF_MSIP:     begin rd_value = {63'b0, msip}; rd_mapped = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Read FSM state register; the response is captured on AR acceptance and
  // held until the master takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_state_next;
      if (ar_hs) begin
        s_rdata <= rd_value;
        s_rresp <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Read FSM next state and channel outputs.
  always_comb begin
    r_state_next = r_state;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) r_state_next = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Timer registers. A software mtime write with any strobe set replaces the
  // tick increment for that cycle; the tick counter keeps its own cadence.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
      if (commit && sel_mtime && (wr_strb != 8'h00)) mtime <= merge_bytes(mtime, wr_data, wr_strb);
      else if (tick)                                  mtime <= mtime + 64'd1;
      if (commit && sel_mtimecmp) mtimecmp <= merge_bytes(mtimecmp, wr_data, wr_strb);
      mtip <= (mtime >= mtimecmp);
    end
  end

`ifdef CLINT_MSIP_EN
  logic msip_q;

  // Software interrupt bit; only byte 0 / bit 0 is meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= 1'b0;
    end else if (commit && (wr_addr == OFF_MSIP) && wr_strb[0]) begin
      msip_q <= wr_data[0];
    end
  end

  assign msip = msip_q;
`else
  assign msip = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_clint_slave.sv
// tb_axi_lite_clint_slave
//   Self-checking bench for axi_lite_clint_slave. Directed scenarios cover
//   reset, timer reads, mtip timing, channel ordering, strobes, unmapped
//   offsets, msip and reset during a transaction. These are followed by
//   randomized transactions. Expected values come from an arithmetic model:
//   mtime after edge n = base + floor(n/TICK_DIV) - floor(base_edge/TICK_DIV).
module tb_axi_lite_clint_slave;

  localparam int         TICK_DIV = 1;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [7:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, mtip, msip;
  logic [1:0]  s_bresp, s_rresp;

  int          checks = 0;
  int          passed = 0;
  int          edge_cnt = 0;

  logic [63:0] mt_base_val;
  int          mt_base_edge;
  logic [63:0] model_cmp;
  logic        model_msip;

  axi_lite_clint_slave #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mtip(mtip), .msip(msip)
  );

  always #5 clk = ~clk;

  // Counts clock edges since reset was released; edge 1 is the first live edge.
  always @(posedge clk) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
  endtask

  function automatic logic [63:0] modelMtime(input int n);
    return mt_base_val + 64'(n / TICK_DIV) - 64'(mt_base_edge / TICK_DIV);
  endfunction

  function automatic logic [63:0] mergeBytes(input logic [63:0] old_val, input logic [63:0] new_val, input logic [7:0] strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  function automatic void modelReset();
    mt_base_val  = 64'd0;
    mt_base_edge = 0;
    model_cmp    = '1;
    model_msip   = 1'b0;
  endfunction

  // Applies a committed write (commit edge w) to the model and returns the response.
  function automatic logic [1:0] modelWrite(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb, input int w);
    logic [63:0] v;
    case (addr & 16'hFFF8)
      16'h4000: begin model_cmp = mergeBytes(model_cmp, data, strb); return OKAY; end
      16'hBFF8: begin
        if (strb != 8'h00) begin
          v = mergeBytes(modelMtime(w - 1), data, strb);
          mt_base_val  = v;
          mt_base_edge = w;
        end
        return OKAY;
      end
`ifdef CLINT_MSIP_EN
      16'h0000: begin if (strb[0]) model_msip = data[0]; return OKAY; end
`endif
      default: return SLVERR;
    endcase
  endfunction

  // Value returned for a read accepted at edge n (register contents before that edge).
  function automatic logic [63:0] modelRead(input logic [15:0] addr, input int n, output logic [1:0] resp);
    resp = OKAY;
    case (addr & 16'hFFF8)
      16'h4000: return model_cmp;
      16'hBFF8: return modelMtime(n - 1);
`ifdef CLINT_MSIP_EN
      16'h0000: return {63'b0, model_msip};
`endif
      default: begin resp = SLVERR; return 64'd0; end
    endcase
  endfunction

  task automatic axiWrite(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output int commit_edge);
    bit aw_done, w_done, aw_fire, w_fire, fire;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; commit_edge = 0; resp = 2'bxx;
    s_awaddr = {32'($urandom()), 16'($urandom()), addr};
    s_wdata  = data;
    s_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_wvalid  = !w_done && (cyc >= w_dly);
      checkOutput("bvalid_early", s_bvalid, 0);
      @(negedge clk);
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      commit_edge = edge_cnt;
      cyc++;
    end
    s_awvalid = 0;
    s_wvalid  = 0;
    checkOutput("aw_w_handshake", {63'b0, aw_done && w_done}, 1);
    checkOutput("bvalid_lat", s_bvalid, 1);
    repeat (b_dly) begin
      @(posedge clk); #1;
      checkOutput("bvalid_hold", s_bvalid, 1);
    end
    s_bready = 1; fire = 0; cyc = 0;
    while (!fire && cyc < 20) begin
      @(negedge clk);
      fire = s_bvalid;
      resp = s_bresp;
      @(posedge clk); #1;
      cyc++;
    end
    s_bready = 0;
    checkOutput("b_handshake", {63'b0, fire}, 1);
    checkOutput("bvalid_drop", s_bvalid, 0);
  endtask

  task automatic axiRead(input logic [15:0] addr, input int r_dly,
                         output logic [63:0] data, output logic [1:0] resp, output int ar_edge);
    bit fire;
    int cyc;
    logic [63:0] held;
    s_araddr = {32'($urandom()), 16'($urandom()), addr};
    s_arvalid = 1; fire = 0; cyc = 0; data = '0; resp = 2'bxx;
    while (!fire && cyc < 20) begin
      @(negedge clk);
      fire = s_arready;
      @(posedge clk); #1;
      cyc++;
    end
    s_arvalid = 0;
    ar_edge = edge_cnt;
    checkOutput("ar_handshake", {63'b0, fire}, 1);
    checkOutput("rvalid_lat", s_rvalid, 1);
    held = s_rdata;
    repeat (r_dly) begin
      @(posedge clk); #1;
      checkOutput("rdata_hold", s_rdata, held);
    end
    s_rready = 1; fire = 0; cyc = 0;
    while (!fire && cyc < 20) begin
      @(negedge clk);
      fire = s_rvalid;
      data = s_rdata;
      resp = s_rresp;
      @(posedge clk); #1;
      cyc++;
    end
    s_rready = 0;
    checkOutput("r_handshake", {63'b0, fire}, 1);
    checkOutput("rvalid_drop", s_rvalid, 0);
  endtask

  task automatic checkSideband(input string tag);
    checkOutput({tag, "_mtip"}, mtip, {63'b0, modelMtime(edge_cnt - 1) >= model_cmp});
    checkOutput({tag, "_msip"}, msip, {63'b0, model_msip});
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                         input int aw_dly, input int w_dly, input int b_dly, input string tag);
    logic [1:0] r, exp_r;
    int e;
    axiWrite(addr, data, strb, aw_dly, w_dly, b_dly, r, e);
    exp_r = modelWrite(addr, data, strb, e);
    checkOutput({tag, "_bresp"}, {62'b0, r}, {62'b0, exp_r});
    checkSideband(tag);
  endtask

  task automatic doRead(input logic [15:0] addr, input int r_dly, input string tag);
    logic [63:0] d, exp_d;
    logic [1:0] r, exp_r;
    int e;
    axiRead(addr, r_dly, d, r, e);
    exp_d = modelRead(addr, e, exp_r);
    checkOutput({tag, "_rdata"}, d, exp_d);
    checkOutput({tag, "_rresp"}, {62'b0, r}, {62'b0, exp_r});
    checkSideband(tag);
  endtask

  // One randomized transaction: random offset, direction, data, strobe and delays.
  task automatic applyStimulus();
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    case ($urandom_range(0, 3))
      0:       a = 16'h0000;
      1:       a = 16'h4000;
      2:       a = 16'hBFF8;
      default: a = 16'($urandom());
    endcase
    if ($urandom_range(0, 1) == 1) begin
      d = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) d = modelMtime(edge_cnt) + 64'($urandom_range(0, 6));
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'hFF;
      doWrite(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rnd_wr");
    end else begin
      doRead(a, $urandom_range(0, 2), "rnd_rd");
    end
  endtask

  initial begin
    rst = 1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_awready", s_awready, 1);
    checkOutput("rst_wready", s_wready, 1);
    checkOutput("rst_arready", s_arready, 1);
    checkOutput("rst_bvalid", s_bvalid, 0);
    checkOutput("rst_rvalid", s_rvalid, 0);
    checkOutput("rst_bresp", {62'b0, s_bresp}, 0);
    checkOutput("rst_rresp", {62'b0, s_rresp}, 0);
    checkOutput("rst_rdata", s_rdata, 0);
    checkOutput("rst_mtip", mtip, 0);
    checkOutput("rst_msip", msip, 0);
    rst = 0;

    // mtime read early after reset
    while (edge_cnt < 9) begin @(posedge clk); #1; end
    doRead(16'hBFF8, 0, "mtime_early");

    // mtip follows mtime >= mtimecmp one cycle late
    doWrite(16'h4000, 64'h20, 8'hFF, 0, 0, 0, "cmp20");
    while (edge_cnt < 48) begin
      @(posedge clk); #1;
      checkOutput("mtip_track", mtip, {63'b0, modelMtime(edge_cnt - 1) >= model_cmp});
    end
    checkOutput("mtip_high", mtip, 1);
    doWrite(16'h4000, '1, 8'hFF, 0, 0, 0, "cmp_ones");
    checkOutput("mtip_fall", mtip, 0);

    // W leads AW by 3 cycles, response held off for 4 cycles
    doWrite(16'h4000, 64'hDEAD_BEEF_0123_4567, 8'hFF, 3, 0, 4, "w_first");
    doRead(16'h4000, 1, "w_first_rb");
    doWrite(16'h4000, 64'h0000_0000_FFFF_0000, 8'hF0, 0, 2, 0, "aw_first");
    doRead(16'h4000, 0, "aw_first_rb");

    // Partial-strobe and zero-strobe mtime writes
    doWrite(16'hBFF8, 64'h1122334455667788, 8'h0F, 0, 0, 0, "mtime_strb");
    doRead(16'hBFF8, 0, "mtime_strb_rb");
    doWrite(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, 0, 0, "mtime_wrap");
    doRead(16'hBFF8, 2, "mtime_wrap_rb");
    doWrite(16'hBFF8, 64'h1234, 8'h00, 0, 0, 0, "mtime_zero");
    doRead(16'hBFF8, 0, "mtime_zero_rb");

    // Unmapped offset
    doWrite(16'h8000, 64'hA5A5, 8'hFF, 0, 0, 0, "unmapped_wr");
    doRead(16'h8000, 0, "unmapped_rd");

    // Software interrupt register
    doWrite(16'h0000, 64'h1, 8'h01, 0, 0, 0, "msip_set");
    doRead(16'h0000, 0, "msip_rb");
    doWrite(16'h0000, 64'h0, 8'hFF, 1, 0, 0, "msip_clr");

    for (int i = 0; i < 60; i++) applyStimulus();

    // Reset while a read response is pending and a W beat is latched
    s_araddr = 64'hBFF8; s_arvalid = 1;
    s_wdata = 64'hFFFF_0000_FFFF_0000; s_wstrb = 8'hFF; s_wvalid = 1;
    @(posedge clk); #1;
    s_arvalid = 0; s_wvalid = 0;
    checkOutput("pre_rst_rvalid", s_rvalid, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    modelReset();
    checkOutput("mid_rst_rvalid", s_rvalid, 0);
    checkOutput("mid_rst_arready", s_arready, 1);
    checkOutput("mid_rst_wready", s_wready, 1);
    checkOutput("mid_rst_rdata", s_rdata, 0);
    checkOutput("mid_rst_mtip", mtip, 0);
    doRead(16'hBFF8, 0, "post_rst_mtime");
    doWrite(16'h4000, 64'h5, 8'h01, 0, 0, 0, "post_rst_cmp");
    doRead(16'h4000, 0, "post_rst_cmp_rb");
    repeat (3) begin @(posedge clk); #1; end
    checkSideband("post_rst_final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_clint_slave.md
# axi_lite_clint_slave

AXI-lite responder implementing a CLINT-style machine timer (mtime/mtimecmp) and optional software-interrupt register. It sits on the MMIO side of the system bus, answering the core's MMIO AXI-lite master. It drives the machine timer (MTIP) and machine software (MSIP) interrupt lines back toward the core's interrupt logic. All AXI-lite channels are discrete ports: 64-bit address, 64-bit data, 8-bit strobe.

## Interface
- ADDR_WIDTH, 64, AXI address width; only addr[15:0] decoded.
- DATA_WIDTH, 64, AXI data width; fixed at 64.
- TICK_DIV, 1, clock cycles per mtime increment; valid range 1..65535.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid, s_awready  in/out  1  write-address handshake.
- s_wdata  in  64  write data.
- s_wstrb  in  8  write byte strobes.
- s_wvalid, s_wready  in/out  1  write-data handshake.
- s_bresp  out  2  write response.
- s_bvalid, s_bready  out/in  1  write-response handshake.
- s_araddr  in  ADDR_WIDTH  read address.
- s_arvalid, s_arready  in/out  1  read-address handshake.
- s_rdata  out  64  read data.
- s_rresp  out  2  read response.
- s_rvalid, s_rready  out/in  1  read-data handshake.
- mtip  out  1  timer interrupt pending; registered.
- msip  out  1  software interrupt pending.

## Operation
- Register map, decoded on addr[15:3] with 8-byte alignment:
  - 0x0000 msip: bit0 only; other bits read 0.
  - 0x4000 mtimecmp: 64-bit.
  - 0xBFF8 mtime: 64-bit.
- Any other offset returns SLVERR (2'b10): writes are dropped and reads return 0. Mapped offsets return OKAY (2'b00).
- Writes are byte-granular per s_wstrb. A write with s_wstrb=0 is OKAY and changes nothing.
- Write FSM states:
  - W_IDLE: s_awready = !aw_captured; s_wready = !w_captured. AW and W are accepted in either order or in the same cycle, and each is latched. Once both are held, the register is updated and the FSM moves to W_RESP.
  - W_RESP: s_bvalid=1 until s_bready; then back to W_IDLE with both captured flags cleared.
- Read FSM states:
  - R_IDLE: s_arready=1. On handshake, s_rdata/s_rresp are registered from the current register values and the FSM moves to R_DATA.
  - R_DATA: s_rvalid=1 and s_rdata/s_rresp held stable until s_rready; then back to R_IDLE.
- Read and write FSMs are independent. A read accepted in the same cycle as a write commit returns the pre-write value.
- Tick counter: counts 0..TICK_DIV-1. When it reaches TICK_DIV-1 it wraps to 0 and mtime increments by 1. mtime wraps from 2^64-1 to 0.
- A software write to mtime in the same cycle as a tick wins: the written value is loaded and no increment is applied. The tick counter is unaffected.
- mtip is registered from the unsigned comparison mtime >= mtimecmp, evaluated on the values at the current edge.

## Timing
- Reset values: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, mtime=0, mtimecmp=all-ones, msip=0, mtip=0, tick counter=0, both FSMs in IDLE.
- Reset asserted mid-transaction aborts it: the pending B or R beat is dropped and no register write commits.
- Write latency: s_bvalid rises on the cycle after the later of the AW/W handshakes. The register value is visible to reads from that same cycle.
- Read latency: s_rvalid rises the cycle after the AR handshake. Sustained throughput is 1 read per 2 cycles when s_rready is held high.
- mtip lags the mtime/mtimecmp condition by 1 cycle.
- After a mtimecmp write, mtip updates 1 cycle after s_bvalid rises.
- Bus-visible state does not change while s_bvalid or s_rvalid is held.

## Configuration
- CLINT_MSIP_EN defined: the msip register exists at 0x0000 and the msip output follows bit0.
- CLINT_MSIP_EN undefined: offset 0x0000 decodes as unmapped (SLVERR, reads 0) and msip is tied to 0.

## Test plan
- Reset, then read 0xBFF8 at about cycle 10 with TICK_DIV=1 -> OKAY; rdata equals the mtime count at AR acceptance (about 10); mtip=0.
- Write mtimecmp=0x20 with strobe 0xFF, then wait -> mtip rises exactly 1 cycle after mtime reaches 0x20. Then write mtimecmp=all-ones -> mtip falls.
- W presented 3 cycles before AW, with s_bready held low for 4 cycles -> the register is updated exactly once; s_bvalid stays high until s_bready; bresp=OKAY.
- Write 0x1122334455667788 to mtime with s_wstrb=0x0F over an mtime of 0 -> readback 0x0000000055667788 plus elapsed ticks. Write at a tick edge -> loaded value held, no increment that cycle.
- Read and write 0x8000 -> SLVERR on both; rdata=0. With CLINT_MSIP_EN: writing 0x1 to 0x0000 sets msip=1. Without it: 0x0000 returns SLVERR and msip stays 0.
- Assert rst while s_rvalid=1 and s_rready=0 -> the next cycle shows s_rvalid=0, s_arready=1, mtime=0.
